// File: rtl/bcd_to_binary_seq.sv
// Digit-serial BCD to binary converter: one BCD digit per clock, most significant first,
// through a single x10 accumulate stage, with sign-marker, invalid-digit and overflow reporting.
module bcd_to_binary_seq #(
  parameter int DIGITS     = 11,
  parameter int WIDTH      = 32,
  parameter bit SIGNED_OUT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic                  done,
  output logic [WIDTH-1:0]      binary_out,
  output logic                  neg,
  output logic                  overflow,
  output logic                  invalid
);

  // Handshake: start is taken only in a cycle where ready=1 (and rst=0); bcd_in is sampled
  // in that same cycle. done is high for exactly one cycle and the result outputs are valid
  // from that cycle until the next done or rst.

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] LIM_U = (ONE << WIDTH) - ONE;
  localparam logic [WIDTH:0] LIM_P = (ONE << (WIDTH-1)) - ONE;
  localparam logic [WIDTH:0] LIM_N = ONE << (WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] sr_q, sr_d;
  logic [WIDTH:0]      acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sneg_q, sneg_d;
  logic                sinv_q, sinv_d;
  logic                sraw_q, sraw_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic                inv_q, inv_d;

  logic [3:0]          digit;
  logic [3:0]          dval;
  logic [WIDTH+4:0]    step;
  logic [WIDTH:0]      acc_step;
  logic [WIDTH:0]      acc_negated;
  logic                neg_step, inv_step, raw_step, mag_ovf;

  always_comb begin
    digit       = sr_q[4*DIGITS-1 -: 4];
    dval        = (digit <= 4'd9) ? digit : 4'd0;
    step        = ({4'b0, acc_q} * (WIDTH+5)'(10)) + (WIDTH+5)'(dval);
    acc_step    = step[WIDTH:0];
    acc_negated = -acc_step;
    neg_step    = sneg_q | (digit == 4'hE);
    inv_step    = sinv_q | ((digit > 4'd9) && (digit != 4'hE));
    raw_step    = sraw_q | (|step[WIDTH+4:WIDTH+1]);
    if (SIGNED_OUT) mag_ovf = neg_step ? (acc_step > LIM_N) : (acc_step > LIM_P);
    else            mag_ovf = acc_step > LIM_U;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sneg_d  = sneg_q;
    sinv_d  = sinv_q;
    sraw_d  = sraw_q;
    bin_d   = bin_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    inv_d   = inv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = bcd_in;
          acc_d   = '0;
          cnt_d   = CW'(DIGITS-1);
          sneg_d  = 1'b0;
          sinv_d  = 1'b0;
          sraw_d  = 1'b0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        sr_d   = sr_q << 4;
        acc_d  = acc_step;
        sneg_d = neg_step;
        sinv_d = inv_step;
        sraw_d = raw_step;
        cnt_d  = cnt_q - 1'b1;
        // Results are registered on the last digit so they are valid in the done cycle.
        if (cnt_q == '0) begin
          state_d = S_FIN;
          neg_d   = neg_step;
          inv_d   = inv_step;
          if (inv_step) begin
            bin_d = '0;
            ovf_d = 1'b0;
          end else begin
            ovf_d = mag_ovf | raw_step;
            bin_d = (SIGNED_OUT && neg_step) ? acc_negated[WIDTH-1:0] : acc_step[WIDTH-1:0];
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sneg_q  <= 1'b0;
      sinv_q  <= 1'b0;
      sraw_q  <= 1'b0;
      bin_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sneg_q  <= sneg_d;
      sinv_q  <= sinv_d;
      sraw_q  <= sraw_d;
      bin_q   <= bin_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      inv_q   <= inv_d;
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign done       = (state_q == S_FIN);
  assign binary_out = bin_q;
  assign neg        = neg_q;
  assign overflow   = ovf_q;
  assign invalid    = inv_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Bench for bcd_to_binary_seq: three configurations (unsigned 32, signed 32, signed 16/4 digits)
// driven with directed and random BCD operands and checked against an arithmetic model.
module tb_bcd_to_binary_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_a = '0;
  logic [43:0] bcd_a [3];
  logic [2:0]  ready_a, done_a, neg_a, ovf_a, inv_a;
  logic [31:0] bin_a [3];
  logic [15:0] bin2;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  bcd_to_binary_seq #(.DIGITS(11), .WIDTH(32), .SIGNED_OUT(1'b0)) u_uns (
    .clk(clk), .rst(rst), .start(start_a[0]), .bcd_in(bcd_a[0]),
    .ready(ready_a[0]), .done(done_a[0]), .binary_out(bin_a[0]),
    .neg(neg_a[0]), .overflow(ovf_a[0]), .invalid(inv_a[0]));

  bcd_to_binary_seq #(.DIGITS(11), .WIDTH(32), .SIGNED_OUT(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .start(start_a[1]), .bcd_in(bcd_a[1]),
    .ready(ready_a[1]), .done(done_a[1]), .binary_out(bin_a[1]),
    .neg(neg_a[1]), .overflow(ovf_a[1]), .invalid(inv_a[1]));

  bcd_to_binary_seq #(.DIGITS(4), .WIDTH(16), .SIGNED_OUT(1'b1)) u_small (
    .clk(clk), .rst(rst), .start(start_a[2]), .bcd_in(bcd_a[2][15:0]),
    .ready(ready_a[2]), .done(done_a[2]), .binary_out(bin2),
    .neg(neg_a[2]), .overflow(ovf_a[2]), .invalid(inv_a[2]));

  assign bin_a[2] = {16'h0, bin2};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int digits_of(input int inst);
    return (inst == 2) ? 4 : 11;
  endfunction

  // Reference: evaluate the true decimal value, then apply the format's range and wrap rules.
  function automatic void model(input int inst, input logic [43:0] bcd,
                                output logic [31:0] e_bin, output logic e_neg,
                                output logic e_ovf, output logic e_inv);
    int     nd   = digits_of(inst);
    int     w    = (inst == 2) ? 16 : 32;
    bit     sgn  = (inst != 0);
    longint v    = 0;
    longint lim;
    longint mask = (longint'(1) << w) - 1;
    logic [3:0] d;
    e_neg = 1'b0;
    e_inv = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = bcd[4*i +: 4];
      if (d <= 4'd9) v = v * 10 + longint'(d);
      else begin
        v = v * 10;
        if (d == 4'hE) e_neg = 1'b1;
        else           e_inv = 1'b1;
      end
    end
    if (!sgn)      lim = mask;
    else if (e_neg) lim = longint'(1) << (w - 1);
    else           lim = (longint'(1) << (w - 1)) - 1;
    e_ovf = (v > lim);
    e_bin = (sgn && e_neg) ? 32'((-v) & mask) : 32'(v & mask);
    if (e_inv) begin
      e_bin = '0;
      e_ovf = 1'b0;
    end
  endfunction

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_ready"}, 64'(ready_a[i]), 64'd1);
      check({tag, "_done"},  64'(done_a[i]),  64'd0);
      check({tag, "_bin"},   64'(bin_a[i]),   64'd0);
      check({tag, "_neg"},   64'(neg_a[i]),   64'd0);
      check({tag, "_ovf"},   64'(ovf_a[i]),   64'd0);
      check({tag, "_inv"},   64'(inv_a[i]),   64'd0);
    end
  endtask

  // Drives one conversion, measures edges from acceptance to done, checks results.
  // poke>0 re-asserts start with a different operand that many cycles after acceptance.
  task automatic run_conv(input int inst, input logic [43:0] bcd, input string tag,
                          input int poke);
    int          nd = digits_of(inst);
    int          k;
    int          extra;
    logic [31:0] e_bin;
    logic        e_neg, e_ovf, e_inv;
    model(inst, bcd, e_bin, e_neg, e_ovf, e_inv);
    @(negedge clk);
    check({tag, "_ready_before"}, 64'(ready_a[inst]), 64'd1);
    start_a[inst] = 1'b1;
    bcd_a[inst]   = bcd;
    @(posedge clk);
    #1;
    start_a[inst] = 1'b0;
    bcd_a[inst]   = {12'($urandom), $urandom};
    check({tag, "_ready_busy"}, 64'(ready_a[inst]), 64'd0);
    k = 0;
    while (k < nd + 4) begin
      if (poke > 0 && k == poke) begin
        start_a[inst] = 1'b1;
        bcd_a[inst]   = {12'($urandom), $urandom};
      end
      @(posedge clk);
      #1;
      start_a[inst] = 1'b0;
      k++;
      if (done_a[inst]) break;
    end
    check({tag, "_latency"}, 64'(k), 64'(nd));
    check({tag, "_bin"}, 64'(bin_a[inst]), 64'(e_bin));
    check({tag, "_neg"}, 64'(neg_a[inst]), 64'(e_neg));
    check({tag, "_ovf"}, 64'(ovf_a[inst]), 64'(e_ovf));
    check({tag, "_inv"}, 64'(inv_a[inst]), 64'(e_inv));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(done_a[inst]), 64'd0);
    check({tag, "_ready_after"}, 64'(ready_a[inst]), 64'd1);
    if (poke > 0) begin
      extra = 0;
      repeat (nd + 2) begin
        @(posedge clk);
        #1;
        if (done_a[inst]) extra++;
      end
      check({tag, "_no_second_done"}, 64'(extra), 64'd0);
    end
  endtask

  function automatic logic [43:0] rand_bcd(input int inst);
    int          nd = digits_of(inst);
    int          lz = $urandom_range(0, nd);
    int          r;
    logic [43:0] b  = '0;
    logic [3:0]  bad [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
    for (int i = 0; i < nd; i++) begin
      r = $urandom_range(0, 19);
      if (i >= nd - lz)  b[4*i +: 4] = 4'h0;
      else if (r < 15)   b[4*i +: 4] = 4'($urandom_range(0, 9));
      else if (r < 17)   b[4*i +: 4] = 4'hE;
      else if (r < 18)   b[4*i +: 4] = bad[$urandom_range(0, 4)];
      else               b[4*i +: 4] = 4'h9;
    end
    return b;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) bcd_a[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    run_conv(0, 44'h01234567890, "default", 0);
    run_conv(0, 44'hE0000000042, "sign_uns", 0);
    run_conv(1, 44'hE0000000042, "sign_sgn", 0);
    run_conv(0, 44'hE0000000000, "negzero_uns", 0);
    run_conv(1, 44'hE0000000000, "negzero_sgn", 0);
    run_conv(0, 44'h09999999999, "ovf_uns", 0);
    run_conv(0, 44'h04294967295, "max_uns", 0);
    run_conv(1, 44'hE2147483648, "min_sgn", 0);
    run_conv(1, 44'h02147483648, "ovf_sgn", 0);
    run_conv(0, 44'h000000000A5, "invalid", 0);
    run_conv(0, 44'hEE000000007, "double_sign", 0);
    run_conv(2, 44'h9999, "small_max", 0);
    run_conv(2, 44'hE999, "small_neg", 0);
    run_conv(0, 44'h00000031415, "busy_start", 3);

    // Abort mid-conversion, with a start held alongside rst that must be ignored.
    @(negedge clk);
    start_a[0] = 1'b1;
    bcd_a[0]   = 44'h00000000777;
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst        = 1'b1;
    start_a[0] = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("abort");
    @(negedge clk);
    rst        = 1'b0;
    start_a[0] = 1'b0;
    @(posedge clk);
    #1;
    check("abort_start_ignored", 64'(ready_a[0]), 64'd1);
    run_conv(0, 44'h00000000777, "after_abort", 0);

    for (int n = 0; n < 40; n++) begin
      for (int inst = 0; inst < 3; inst++) begin
        run_conv(inst, rand_bcd(inst), $sformatf("rand%0d_%0d", n, inst), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
